// File: rtl/arbiter_pkg.sv
// Shared arbiter definitions: arbitration mode selectors and FSM state encoding.
package arbiter_pkg;

  localparam int ARB_MODE_FIXED = 0;
  localparam int ARB_MODE_RR    = 1;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational N-wide priority encoder: lowest index first (fixed mode) or
// first set bit after i_last, wrapping modulo N (round-robin mode).
module rr_pick
  import arbiter_pkg::*;
#(
  parameter int N    = 4,
  parameter int MODE = ARB_MODE_RR,
  parameter int W    = $clog2(N)
) (
  input  logic [N-1:0] i_c,
  input  logic [W-1:0] i_last,
  output logic [W-1:0] o_idx,
  output logic         o_any
);

  logic [W-1:0] w_j;

  // Scan from the lowest priority to the highest so the last hit wins.
  always_comb begin
    o_idx = '0;
    w_j   = '0;
    o_any = |i_c;
    if (MODE == ARB_MODE_FIXED) begin
      for (int i = N - 1; i >= 0; i--) begin
        w_j = W'(i);
        if (i_c[w_j]) o_idx = w_j;
      end
    end else begin
      for (int k = N; k >= 1; k--) begin
        w_j = W'((int'(i_last) + k) % N);
        if (i_c[w_j]) o_idx = w_j;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// N-requester arbiter with fixed-priority or round-robin selection, grant
// hold while requested, and an optional hold limit that forces rotation.
module rr_arbiter
  import arbiter_pkg::*;
#(
  parameter int N        = 4,
  parameter int MODE     = ARB_MODE_RR,
  parameter int MAX_HOLD = 8
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic [N-1:0]         i_req,
  output logic [N-1:0]         o_gnt,
  output logic [$clog2(N)-1:0] o_gnt_id,
  output logic                 o_busy
);

  localparam int W  = $clog2(N);
  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HW-1:0] HOLD_LIM = HW'(MAX_HOLD);
  localparam logic [N-1:0]  ONE_N    = {{(N-1){1'b0}}, 1'b1};

  arb_state_e      r_state;
  logic [W-1:0]    r_owner;
  logic [W-1:0]    r_last;
  logic [HW-1:0]   r_hold_cnt;
  logic [N-1:0]    r_gnt;
  logic            r_busy;

  logic            w_owner_req;
  logic            w_expire;
  logic [N-1:0]    w_cand;
  logic [W-1:0]    w_idx;
  logic            w_any;
  logic [N-1:0]    w_idx_oh;

  assign w_owner_req = i_req[r_owner];
  assign w_expire    = (r_state == ARB_GRANT) && (MAX_HOLD != 0) && w_owner_req &&
                       (r_hold_cnt == HOLD_LIM);
  // On expiry the owner is masked out so the single picker finds a contender.
  assign w_cand      = w_expire ? (i_req & ~(ONE_N << r_owner)) : i_req;
  assign w_idx_oh    = ONE_N << w_idx;

  rr_pick #(
    .N    (N),
    .MODE (MODE),
    .W    (W)
  ) u_pick (
    .i_c    (w_cand),
    .i_last (r_last),
    .o_idx  (w_idx),
    .o_any  (w_any)
  );

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_state    <= ARB_IDLE;
      r_owner    <= '0;
      r_last     <= W'(N - 1);
      r_hold_cnt <= '0;
      r_gnt      <= '0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_any) begin
            r_state    <= ARB_GRANT;
            r_owner    <= w_idx;
            r_last     <= w_idx;
            r_hold_cnt <= HW'(1);
            r_gnt      <= w_idx_oh;
            r_busy     <= 1'b1;
          end
        end
        ARB_GRANT: begin
          if (!w_owner_req || w_expire) begin
            if (w_any) begin
              r_owner    <= w_idx;
              r_last     <= w_idx;
              r_hold_cnt <= HW'(1);
              r_gnt      <= w_idx_oh;
            end else if (w_expire) begin
              r_hold_cnt <= HW'(1);
            end else begin
              r_state    <= ARB_IDLE;
              r_hold_cnt <= '0;
              r_gnt      <= '0;
              r_busy     <= 1'b0;
            end
          end else if ((MAX_HOLD != 0) && (r_hold_cnt != HOLD_LIM)) begin
            r_hold_cnt <= r_hold_cnt + HW'(1);
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  assign o_gnt    = r_gnt;
  assign o_gnt_id = r_owner;
  assign o_busy   = r_busy;

endmodule
